// File: rtl/timer_top.sv
// Keypad-entered MM:SS countdown timer with scanned keypad and multiplexed 4-digit display.
// Define TIMER_TOP_BUZZER_EN to compile in the DONE buzzer; otherwise o_buzzer is tied low.
module timer_top #(
    parameter int CLK_HZ          = 10_000_000,
    parameter int SCAN_CYCLES     = 10_000,
    parameter int DEBOUNCE_CYCLES = 100_000
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_start_sw,
    input  logic [4:0] i_key_in,
    output logic [3:0] o_key_out,
    output logic       o_buzzer,
    output logic [7:0] o_led,
    output logic [7:0] o_seg_d,
    output logic [3:0] o_seg_com
);
    localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TICK_W = $clog2(CLK_HZ + 1);
    localparam logic [4:0] KEY_START = 5'd13;
    localparam logic [4:0] KEY_CLEAR = 5'd14;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        col_q, col_d;
    logic [4:0]        scan_min_q, scan_min_d, raw_code_q, raw_code_d;
    logic [4:0]        cand_q, cand_d, deb_q, deb_d;
    logic [DEB_W-1:0]  stab_q, stab_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [3:0][3:0]   val_q, val_d;
    logic              slot_end, key_evt, tick_wrap;
    logic [4:0]        samp_code, scan_best;
    logic [3:0]        digit;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h3F; 4'd1: seg7 = 7'h06; 4'd2: seg7 = 7'h5B; 4'd3: seg7 = 7'h4F;
            4'd4: seg7 = 7'h66; 4'd5: seg7 = 7'h6D; 4'd6: seg7 = 7'h7D; 4'd7: seg7 = 7'h07;
            4'd8: seg7 = 7'h7F; 4'd9: seg7 = 7'h6F;
            default: seg7 = 7'h40;
        endcase
    endfunction

    // Keypad scan: lowest code seen over one full 4-column sweep becomes the raw code.
    always_comb begin
        slot_end   = (scan_cnt_q == SCAN_W'(SCAN_CYCLES - 1));
        scan_cnt_d = slot_end ? '0 : scan_cnt_q + SCAN_W'(1);
        col_d      = slot_end ? col_q + 2'd1 : col_q;
        samp_code  = '0;
        for (int r = 4; r >= 0; r--)
            if (i_key_in[r]) samp_code = 5'(r * 4 + int'(col_q) + 1);
        scan_best = (samp_code != '0 && (scan_min_q == '0 || samp_code < scan_min_q))
                    ? samp_code : scan_min_q;
        scan_min_d = scan_min_q;
        raw_code_d = raw_code_q;
        if (slot_end) begin
            if (col_q == 2'd3) begin
                raw_code_d = scan_best;
                scan_min_d = '0;
            end else begin
                scan_min_d = scan_best;
            end
        end
    end

    // Debounce: a key event fires only on a 0 -> nonzero change of the accepted code.
    always_comb begin
        cand_d = raw_code_q;
        stab_d = stab_q;
        deb_d  = deb_q;
        if (raw_code_q != cand_q)
            stab_d = '0;
        else if (stab_q != DEB_W'(DEBOUNCE_CYCLES - 1))
            stab_d = stab_q + DEB_W'(1);
        else
            deb_d = cand_q;
        key_evt = (deb_q == '0) && (deb_d != '0);
    end

    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        tick_d    = tick_q;
        tick_wrap = (tick_q == TICK_W'(CLK_HZ - 1));
        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (key_evt) begin
                    if (deb_d >= 5'd1 && deb_d <= 5'd10)
                        val_d = {val_q[2:0], (deb_d == 5'd10) ? 4'd0 : deb_d[3:0]};
                    else if (deb_d == KEY_CLEAR)
                        val_d = '0;
                    else if (deb_d == KEY_START && val_q != '0 && i_start_sw)
                        state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (key_evt && deb_d == KEY_CLEAR) begin
                    state_d = S_IDLE;
                    val_d   = '0;
                    tick_d  = '0;
                end else if (!i_start_sw) begin
                    state_d = S_PAUSE;
                end else begin
                    tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
                    if (tick_wrap) begin
                        // Digits are decremented as entered; SS tens above 5 are not normalised.
                        if (val_q[1:0] != '0) begin
                            if (val_q[0] != 4'd0) val_d[0] = val_q[0] - 4'd1;
                            else begin val_d[0] = 4'd9; val_d[1] = val_q[1] - 4'd1; end
                        end else begin
                            val_d[1] = 4'd5;
                            val_d[0] = 4'd9;
                            if (val_q[2] != 4'd0) val_d[2] = val_q[2] - 4'd1;
                            else begin val_d[2] = 4'd9; val_d[3] = val_q[3] - 4'd1; end
                        end
                        if (val_d == '0) state_d = S_DONE;
                    end
                end
            end
            S_PAUSE: begin
                if (key_evt && deb_d == KEY_CLEAR) begin
                    state_d = S_IDLE;
                    val_d   = '0;
                    tick_d  = '0;
                end else if (key_evt && deb_d == KEY_START && i_start_sw) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                // Tick counter keeps running here to time the display blink.
                tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
                if (key_evt || !i_start_sw) begin
                    state_d = S_IDLE;
                    val_d   = '0;
                    tick_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rstn) begin
            state_q    <= S_IDLE;
            scan_cnt_q <= '0;
            col_q      <= '0;
            scan_min_q <= '0;
            raw_code_q <= '0;
            cand_q     <= '0;
            stab_q     <= '0;
            deb_q      <= '0;
            tick_q     <= '0;
            val_q      <= '0;
        end else begin
            state_q    <= state_d;
            scan_cnt_q <= scan_cnt_d;
            col_q      <= col_d;
            scan_min_q <= scan_min_d;
            raw_code_q <= raw_code_d;
            cand_q     <= cand_d;
            stab_q     <= stab_d;
            deb_q      <= deb_d;
            tick_q     <= tick_d;
            val_q      <= val_d;
        end
    end

`ifdef TIMER_TOP_BUZZER_EN
    localparam int BUZ_HALF = (CLK_HZ / 2000 > 0) ? CLK_HZ / 2000 : 1;
    localparam int BUZ_W    = $clog2(BUZ_HALF + 1);
    logic [BUZ_W-1:0] buz_cnt_q, buz_cnt_d;
    logic             buz_q, buz_d;

    always_comb begin
        buz_cnt_d = '0;
        buz_d     = 1'b0;
        if (state_q == S_DONE && state_d == S_DONE) begin
            buz_d = buz_q;
            if (buz_cnt_q == BUZ_W'(BUZ_HALF - 1)) buz_d = ~buz_q;
            else buz_cnt_d = buz_cnt_q + BUZ_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rstn) begin
            buz_cnt_q <= '0;
            buz_q     <= 1'b0;
        end else begin
            buz_cnt_q <= buz_cnt_d;
            buz_q     <= buz_d;
        end
    end

    assign o_buzzer = buz_q;
`else
    assign o_buzzer = 1'b0;
`endif

    // Display shares the scan slot: column 0 slot shows the leftmost digit.
    always_comb begin
        o_key_out = 4'b0001 << col_q;
        o_seg_com = ~(4'b1000 >> col_q);
        digit     = val_q[2'd3 - col_q];
        o_seg_d   = {col_q == 2'd1, seg7(digit)};
        if (state_q == S_DONE && tick_q >= TICK_W'(CLK_HZ / 2)) o_seg_d = '0;
        o_led = {3'b000, deb_q != '0, state_q == S_DONE, state_q == S_PAUSE,
                 state_q == S_RUN, state_q == S_IDLE};
    end
endmodule

// File: tb/tb_timer_top.sv
// Self-checking bench for timer_top: keypad model, decimal-arithmetic reference of the timer value.
module tb_timer_top;
    localparam int CLK_HZ = 1000;
    localparam int SCAN   = 4;
    localparam int DEB    = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_sw = 1'b0;
    logic [4:0]  key_in;
    logic [3:0]  key_out, seg_com;
    logic        buzzer;
    logic [7:0]  led, seg_d;
    logic [20:0] pressed = '0;
    int          checks = 0;
    int          errors = 0;
    int          mval = 0;

    timer_top #(.CLK_HZ(CLK_HZ), .SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DEB)) dut (
        .i_clk(clk), .i_rstn(rst), .i_start_sw(start_sw), .i_key_in(key_in),
        .o_key_out(key_out), .o_buzzer(buzzer), .o_led(led), .o_seg_d(seg_d), .o_seg_com(seg_com)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed code pulls its row high while its column is driven.
    always_comb begin
        key_in = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 4; c++)
                if (key_out[c] && pressed[r * 4 + c + 1]) key_in[r] = 1'b1;
    end

    function automatic logic [6:0] seg_of(input int k);
        case (k)
            0: seg_of = 7'h3F; 1: seg_of = 7'h06; 2: seg_of = 7'h5B; 3: seg_of = 7'h4F;
            4: seg_of = 7'h66; 5: seg_of = 7'h6D; 6: seg_of = 7'h7D; 7: seg_of = 7'h07;
            8: seg_of = 7'h7F; default: seg_of = 7'h6F;
        endcase
    endfunction

    function automatic int tick_model(input int v);
        int mm, ss;
        mm = v / 100;
        ss = v % 100;
        if (ss != 0) ss = ss - 1;
        else begin ss = 59; mm = mm - 1; end
        return mm * 100 + ss;
    endfunction

    function automatic int digit_code(input int d);
        return (d == 0) ? 10 : d;
    endfunction

    task automatic model_key(input int code);
        if (code >= 1 && code <= 10) mval = (mval * 10 + (code == 10 ? 0 : code)) % 10000;
        else if (code == 14) mval = 0;
    endtask

    task automatic press(input int code);
        @(negedge clk);
        pressed[code] = 1'b1;
        repeat (200) @(negedge clk);
        pressed = '0;
        repeat (200) @(negedge clk);
    endtask

    task automatic enter_value(input int v);
        int divs[4] = '{1000, 100, 10, 1};
        for (int i = 0; i < 4; i++) begin
            press(digit_code((v / divs[i]) % 10));
            model_key(digit_code((v / divs[i]) % 10));
        end
    endtask

    // Samples one full multiplex sweep; v = -1 if any digit pattern is unrecognised.
    task automatic read_display(output int v, output bit dp_ok);
        int d[4];
        logic [3:0] m;
        for (int j = 0; j < 4; j++) d[j] = -1;
        dp_ok = 1'b1;
        for (int i = 0; i < 4 * SCAN; i++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                m = 4'b0001 << j;
                if (seg_com == ~m) begin
                    d[j] = -1;
                    for (int k = 0; k < 10; k++) if (seg_d[6:0] == seg_of(k)) d[j] = k;
                    if (seg_d[7] != (j == 2)) dp_ok = 1'b0;
                end
            end
        end
        v = (d[0] < 0 || d[1] < 0 || d[2] < 0 || d[3] < 0) ? -1
            : d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0];
    endtask

    // Presses START and returns 100 cycles after RUN is first observed.
    task automatic start_and_sync(output bit ok);
        ok = 1'b0;
        @(negedge clk);
        pressed[13] = 1'b1;
        for (int i = 0; i < 150 && !ok; i++) begin
            @(negedge clk);
            if (led[1]) ok = 1'b1;
        end
        repeat (100) @(negedge clk);
        pressed = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (key_out !== 4'b0001) begin errors++; $display("FAIL reset_key_out: got %b expected 0001", key_out); end
        checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer: got %b expected 0", buzzer); end
        checks++; if (led !== 8'h01) begin errors++; $display("FAIL reset_led: got %h expected 01", led); end
        checks++; if (seg_com !== 4'b0111) begin errors++; $display("FAIL reset_seg_com: got %b expected 0111", seg_com); end
        checks++; if (seg_d !== 8'h3F) begin errors++; $display("FAIL reset_seg_d: got %h expected 3f", seg_d); end
        rst = 1'b0;
        mval = 0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_entry_fixed();
        int seq[10] = '{10, 7, 7, 7, 6, 7, 7, 7, 4, 2};
        int v;
        bit dp;
        start_sw = 1'b0;
        foreach (seq[i]) begin press(seq[i]); model_key(seq[i]); end
        read_display(v, dp);
        checks++; if (v !== 7742) begin errors++; $display("FAIL entry_fixed_value: got %0d expected 7742", v); end
        checks++; if (!dp) begin errors++; $display("FAIL entry_fixed_dp: colon point wrong"); end
        checks++; if (led !== 8'h01) begin errors++; $display("FAIL entry_fixed_led: got %h expected 01", led); end
    endtask

    task automatic test_entry_random();
        int v, n, code;
        bit dp;
        start_sw = 1'b0;
        for (int round = 0; round < 3; round++) begin
            n = $urandom_range(3, 6);
            for (int i = 0; i < n; i++) begin
                code = $urandom_range(1, 20);
                press(code);
                model_key(code);
            end
            read_display(v, dp);
            checks++; if (v !== mval) begin errors++; $display("FAIL entry_random_value: got %0d expected %0d", v, mval); end
        end
    endtask

    task automatic test_countdown();
        int v;
        bit dp, ok, tog_ok, dark_ok;
        logic prev;
        press(14); model_key(14);
        enter_value(2);
        start_sw = 1'b1;
        start_and_sync(ok);
        checks++; if (!ok) begin errors++; $display("FAIL countdown_run_entry: RUN not seen within 150 cycles"); end
        repeat (750) @(negedge clk);
        read_display(v, dp);
        checks++; if (v !== mval) begin errors++; $display("FAIL countdown_before_tick: got %0d expected %0d", v, mval); end
        mval = tick_model(mval);
        repeat (250) @(negedge clk);
        read_display(v, dp);
        checks++; if (v !== mval) begin errors++; $display("FAIL countdown_after_tick: got %0d expected %0d", v, mval); end
        repeat (750) @(negedge clk);
        checks++; if (led !== 8'h02) begin errors++; $display("FAIL countdown_still_run: led %h expected 02", led); end
        repeat (200) @(negedge clk);
        checks++; if (led !== 8'h08) begin errors++; $display("FAIL countdown_done: led %h expected 08", led); end
        tog_ok = 1'b1;
        prev = buzzer;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
`ifdef TIMER_TOP_BUZZER_EN
            if (buzzer === prev) tog_ok = 1'b0;
`else
            if (buzzer !== 1'b0) tog_ok = 1'b0;
`endif
            prev = buzzer;
        end
        checks++; if (!tog_ok) begin errors++; $display("FAIL done_buzzer: last %b wrong toggle behaviour", buzzer); end
        repeat (600) @(negedge clk);
        dark_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (seg_d !== 8'h00) dark_ok = 1'b0;
        end
        checks++; if (!dark_ok) begin errors++; $display("FAIL done_blink_dark: seg %h expected 00", seg_d); end
        repeat (400) @(negedge clk);
        read_display(v, dp);
        checks++; if (v !== 0) begin errors++; $display("FAIL done_blink_lit: got %0d expected 0", v); end
        start_sw = 1'b0;
        repeat (3) @(negedge clk);
        mval = 0;
        checks++; if (led !== 8'h01) begin errors++; $display("FAIL done_exit_led: got %h expected 01", led); end
    endtask

    task automatic test_pause();
        int v, val, frozen;
        bit dp, ok;
        val = $urandom_range(2, 9999);
        enter_value(val);
        start_sw = 1'b1;
        start_and_sync(ok);
        checks++; if (!ok) begin errors++; $display("FAIL pause_run_entry: RUN not seen within 150 cycles"); end
        repeat (950) @(negedge clk);
        frozen = tick_model(mval);
        read_display(v, dp);
        checks++; if (v !== frozen) begin errors++; $display("FAIL pause_first_tick: got %0d expected %0d", v, frozen); end
        start_sw = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (led !== 8'h04) begin errors++; $display("FAIL pause_led: got %h expected 04", led); end
        repeat (5000) @(negedge clk);
        read_display(v, dp);
        checks++; if (v !== frozen) begin errors++; $display("FAIL pause_frozen: got %0d expected %0d", v, frozen); end
        start_sw = 1'b1;
        press(13);
        checks++; if (led !== 8'h02) begin errors++; $display("FAIL pause_resume_led: got %h expected 02", led); end
        press(14);
        mval = 0;
        read_display(v, dp);
        checks++; if (v !== 0 || led !== 8'h01) begin errors++; $display("FAIL pause_clear: value %0d led %h expected 0 and 01", v, led); end
    endtask

    task automatic test_hold_multi();
        int v;
        bit dp;
        start_sw = 1'b0;
        @(negedge clk);
        pressed[7] = 1'b1;
        repeat (500) @(negedge clk);
        checks++; if (led !== 8'h11) begin errors++; $display("FAIL hold_led: got %h expected 11", led); end
        repeat (500) @(negedge clk);
        pressed = '0;
        repeat (200) @(negedge clk);
        model_key(7);
        read_display(v, dp);
        checks++; if (v !== mval) begin errors++; $display("FAIL hold_once: got %0d expected %0d", v, mval); end
        pressed[3] = 1'b1;
        pressed[7] = 1'b1;
        repeat (200) @(negedge clk);
        pressed = '0;
        repeat (200) @(negedge clk);
        model_key(3);
        read_display(v, dp);
        checks++; if (v !== mval) begin errors++; $display("FAIL multi_lowest: got %0d expected %0d", v, mval); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        for (int k = 0; k < 2; k++) begin
            press(14); model_key(14);
            enter_value(k == 0 ? 5 : 1);
            start_sw = 1'b1;
            start_and_sync(ok);
            checks++; if (!ok) begin errors++; $display("FAIL rst_mid_run_entry: RUN not seen (case %0d)", k); end
            if (k == 0) begin
                repeat (300) @(negedge clk);
            end else begin
                repeat (1000) @(negedge clk);
                checks++; if (led !== 8'h08) begin errors++; $display("FAIL rst_mid_done_state: led %h expected 08", led); end
            end
            rst = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if ({key_out, buzzer, led, seg_com, seg_d} !== {4'b0001, 1'b0, 8'h01, 4'b0111, 8'h3F}) begin
                errors++;
                $display("FAIL rst_mid_outputs: case %0d key %b buz %b led %h com %b seg %h expected 0001 0 01 0111 3f",
                         k, key_out, buzzer, led, seg_com, seg_d);
            end
            @(negedge clk);
            rst = 1'b0;
            mval = 0;
            repeat (100) @(negedge clk);
            checks++; if (led !== 8'h01 || buzzer !== 1'b0) begin errors++; $display("FAIL rst_mid_after: led %h buz %b expected 01 0", led, buzzer); end
        end
        start_sw = 1'b0;
    endtask

    initial begin
        test_reset();
        test_entry_fixed();
        test_entry_random();
        test_countdown();
        test_pause();
        test_hold_multi();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
